// File: rtl/alu_seq_pkg.sv
// Shared types, opcode map, function codes and decode helper for the ALU op sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } seq_state_t;

  // Exact opcodes of the extended map
  localparam logic [3:0] ADR_OP = 4'b0000;
  localparam logic [3:0] ANR_OP = 4'b0001;
  localparam logic [3:0] ORR_OP = 4'b0010;
  localparam logic [3:0] SBR_OP = 4'b0011;
  localparam logic [3:0] NTR_OP = 4'b0100;
  localparam logic [3:0] SHL_OP = 4'b0101;
  localparam logic [3:0] SHR_OP = 4'b0110;
  localparam logic [3:0] ADA_OP = 4'b1000;
  localparam logic [3:0] ANA_OP = 4'b1010;

  // ADA/ANA ignore opcode[0], so they are matched on their upper three bits
  localparam logic [2:0] ADA_PFX = 3'b100;
  localparam logic [2:0] ANA_PFX = 3'b101;

  // ALU function-select codes
  localparam logic [2:0] ADD_FN = 3'd0;
  localparam logic [2:0] AND_FN = 3'd1;
  localparam logic [2:0] OR_FN  = 3'd2;
  localparam logic [2:0] SUB_FN = 3'd3;
  localparam logic [2:0] NOT_FN = 3'd4;
  localparam logic [2:0] SHL_FN = 3'd5;
  localparam logic [2:0] SHR_FN = 3'd6;
  localparam logic [2:0] NOP_FN = 3'd7;

  typedef struct packed {
    logic [2:0] fn;
    logic       is_shift;
    logic       is_illegal;
  } decode_t;

  // Unmapped opcodes fall through as illegal with a NOP function so nothing stale leaks out
  function automatic decode_t decode_op(input logic [3:0] op);
    decode_t d;
    d.fn         = NOP_FN;
    d.is_shift   = 1'b0;
    d.is_illegal = 1'b1;
    if (op[3:1] == ADA_PFX) begin
      d.fn         = ADD_FN;
      d.is_illegal = 1'b0;
    end else if (op[3:1] == ANA_PFX) begin
      d.fn         = AND_FN;
      d.is_illegal = 1'b0;
    end else begin
      case (op)
        ADR_OP: begin d.fn = ADD_FN; d.is_illegal = 1'b0; end
        ANR_OP: begin d.fn = AND_FN; d.is_illegal = 1'b0; end
        ORR_OP: begin d.fn = OR_FN;  d.is_illegal = 1'b0; end
        SBR_OP: begin d.fn = SUB_FN; d.is_illegal = 1'b0; end
        NTR_OP: begin d.fn = NOT_FN; d.is_illegal = 1'b0; end
        SHL_OP: begin d.fn = SHL_FN; d.is_shift = 1'b1; d.is_illegal = 1'b0; end
        SHR_OP: begin d.fn = SHR_FN; d.is_shift = 1'b1; d.is_illegal = 1'b0; end
        default: ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Purely combinational opcode decoder, shareable with the single-cycle datapath.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] fn,
  output logic       is_shift,
  output logic       is_illegal
);

  decode_t dec;

  // Map the opcode through the shared decode helper
  always_comb begin
    dec        = decode_op(opcode);
    fn         = dec.fn;
    is_shift   = dec.is_shift;
    is_illegal = dec.is_illegal;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU control sequencer: accepts one opcode per handshake and drives
// the ALU select/enable for one cycle, or shamt cycles for shifts, then pulses done.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FN_W     = 3,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [CNT_W-1:0]    shamt,
  output logic [FN_W-1:0]     alu_operation,
  output logic                alu_en,
  output logic                done,
  output logic                illegal
);

  seq_state_t state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [FN_W-1:0]  next_op;
  logic             next_en;
  logic             next_done;
  logic             next_illegal;

  logic [2:0] dec_fn;
  logic       dec_shift;
  logic       dec_illegal;
  logic       accept;

  alu_op_decode u_decode (
    .opcode     (opcode),
    .fn         (dec_fn),
    .is_shift   (dec_shift),
    .is_illegal (dec_illegal)
  );

  // Ready whenever idle or in the final cycle of an op, so streams run without bubbles
  assign in_ready = (state == IDLE) || done;
  assign accept   = in_valid && in_ready;

  // Next state and next registered outputs; a launch path is shared by IDLE, EXEC and final SHIFT
  always_comb begin
    next_state   = IDLE;
    next_cnt     = cnt;
    next_op      = FN_W'(NOP_FN);
    next_en      = 1'b0;
    next_done    = 1'b0;
    next_illegal = 1'b0;

    if (state == SHIFT && cnt != '0) begin
      next_state = SHIFT;
      next_cnt   = cnt - CNT_W'(1);
      next_op    = alu_operation;
      next_en    = 1'b1;
      next_done  = (cnt == CNT_W'(1));
    end else if (accept) begin
      if (dec_illegal) begin
        next_state   = EXEC;
        next_done    = 1'b1;
        next_illegal = 1'b1;
      end else if (dec_shift && shamt == '0) begin
        next_state = EXEC;
        next_done  = 1'b1;
      end else if (dec_shift) begin
        next_state = SHIFT;
        next_cnt   = shamt - CNT_W'(1);
        next_op    = FN_W'(dec_fn);
        next_en    = 1'b1;
        next_done  = (shamt == CNT_W'(1));
      end else begin
        next_state = EXEC;
        next_op    = FN_W'(dec_fn);
        next_en    = 1'b1;
        next_done  = 1'b1;
      end
    end else begin
      next_cnt = '0;
    end
  end

  // State, shift counter and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      alu_operation <= FN_W'(NOP_FN);
      alu_en        <= 1'b0;
      done          <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      state         <= next_state;
      cnt           <= next_cnt;
      alu_operation <= next_op;
      alu_en        <= next_en;
      done          <= next_done;
      illegal       <= next_illegal;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a high-level op model pushes the
// expected per-cycle ALU outputs, and a monitor pops them as the DUT presents them.
module tb_alu_op_sequencer;

  typedef struct {
    int fn;
    int en;
    int dn;
    int ill;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [2:0] shamt;
  logic [2:0] alu_operation;
  logic       alu_en;
  logic       done;
  logic       illegal;

  exp_t sb[$];
  int   fnOf[16];
  int   busyLeft;
  int   checks;
  int   passes;
  bit   monOn;

  alu_op_sequencer #(.OPCODE_W(4), .FN_W(3), .CNT_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .shamt         (shamt),
    .alu_operation (alu_operation),
    .alu_en        (alu_en),
    .done          (done),
    .illegal       (illegal)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Expand one accepted op into its sequence of expected ALU cycles; returns occupancy
  function automatic int pushOp(input int op, input int sh);
    exp_t e;
    if (fnOf[op] < 0) begin
      e = '{fn: 7, en: 0, dn: 1, ill: 1};
      sb.push_back(e);
      return 1;
    end
    if (op == 5 || op == 6) begin
      if (sh == 0) begin
        e = '{fn: 7, en: 0, dn: 1, ill: 0};
        sb.push_back(e);
        return 1;
      end
      for (int i = 0; i < sh; i++) begin
        e = '{fn: fnOf[op], en: 1, dn: (i == sh - 1) ? 1 : 0, ill: 0};
        sb.push_back(e);
      end
      return sh;
    end
    e = '{fn: fnOf[op], en: 1, dn: 1, ill: 0};
    sb.push_back(e);
    return 1;
  endfunction

  // Drive one cycle of inputs at the falling edge and advance the occupancy model
  task automatic applyStimulus(input bit valid, input int op, input int sh);
    bit expReady;
    bit acc;
    int occ;
    @(negedge clk);
    in_valid = valid;
    opcode   = op[3:0];
    shamt    = sh[2:0];
    expReady = (busyLeft <= 1);
    checkOutput("in_ready", int'(in_ready), int'(expReady));
    acc = valid && expReady;
    if (acc) begin
      occ      = pushOp(op, sh);
      busyLeft = occ;
    end else if (busyLeft > 0) begin
      busyLeft = busyLeft - 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom_range(0, 15), 0);
  endtask

  // Hold reset for one edge, abandon any op in flight, then check reset values
  task automatic doReset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    busyLeft = 0;
    @(negedge clk);
    checkOutput("reset_alu_operation", int'(alu_operation), 7);
    checkOutput("reset_alu_en", int'(alu_en), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_illegal", int'(illegal), 0);
    rst_n = 1'b1;
  endtask

  // Monitor: pop an expectation whenever the DUT presents an ALU cycle, else expect idle outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (monOn) begin
        if (alu_en || done || illegal) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("alu_operation", int'(alu_operation), e.fn);
            checkOutput("alu_en", int'(alu_en), e.en);
            checkOutput("done", int'(done), e.dn);
            checkOutput("illegal", int'(illegal), e.ill);
          end
        end else begin
          checkOutput("missing_output", sb.size(), 0);
          checkOutput("idle_alu_operation", int'(alu_operation), 7);
        end
      end
    end
  end

  // Directed scenarios from the opcode map, then randomized traffic
  initial begin
    fnOf = '{0, 1, 2, 3, 4, 5, 6, -1, 0, 0, 1, 1, -1, -1, -1, -1};
    checks   = 0;
    passes   = 0;
    busyLeft = 0;
    monOn    = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    opcode   = 4'd0;
    shamt    = 3'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    monOn = 1'b1;
    doReset();

    applyStimulus(1'b1, 0, 0);
    idle(2);
    applyStimulus(1'b1, 8, 0);
    idle(1);
    applyStimulus(1'b1, 9, 0);
    idle(1);
    applyStimulus(1'b1, 10, 0);
    idle(1);
    applyStimulus(1'b1, 11, 0);
    idle(1);

    applyStimulus(1'b1, 5, 3);
    idle(4);
    applyStimulus(1'b1, 6, 0);
    idle(2);
    applyStimulus(1'b1, 12, 0);
    idle(2);
    applyStimulus(1'b1, 7, 0);
    idle(2);

    applyStimulus(1'b1, 0, 0);
    applyStimulus(1'b1, 2, 0);
    applyStimulus(1'b1, 3, 0);
    idle(2);

    applyStimulus(1'b1, 6, 7);
    idle(8);

    applyStimulus(1'b1, 5, 7);
    idle(3);
    doReset();
    idle(2);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), $urandom_range(0, 15), $urandom_range(0, 7));
    end
    idle(10);
    checkOutput("queue_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
